// File: rtl/bloc_xfer_source.sv
// Block-transfer source: local RAM with a write port, streamed out in bursts over a valid/ready bus.
// Optional build macro BLOC_XFER_BYTE_SWAP_EN swaps the two bytes of every word sent (DATA_W must be 16).
module bloc_xfer_source #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              xfer_req,
    input  logic [ADDR_W-1:0] xfer_addr,
    input  logic [LEN_W-1:0]  xfer_len,
    output logic              xfer_busy,
    output logic [DATA_W-1:0] data_bus,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              xfer_done
);

    typedef enum logic [1:0] {IDLE, READ, SEND} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] cur_addr, addr_nxt;
    logic [LEN_W-1:0]  remaining, rem_nxt;
    logic              busy_nxt, valid_nxt, done_nxt, load_word;

`ifdef BLOC_XFER_BYTE_SWAP_EN
    if (DATA_W != 16) begin : g_width_check
        $error("bloc_xfer_source: byte swap requires DATA_W == 16");
    end

    function automatic logic [DATA_W-1:0] fmt_word(input logic [DATA_W-1:0] w);
        return {w[7:0], w[15:8]};
    endfunction
`else
    function automatic logic [DATA_W-1:0] fmt_word(input logic [DATA_W-1:0] w);
        return w;
    endfunction
`endif

    // Next-state and registered-output decode
    always_comb begin
        state_nxt = state;
        addr_nxt  = cur_addr;
        rem_nxt   = remaining;
        busy_nxt  = xfer_busy;
        valid_nxt = data_valid;
        done_nxt  = 1'b0;
        load_word = 1'b0;
        case (state)
            IDLE: begin
                if (xfer_req) begin
                    if (xfer_len != '0) begin
                        addr_nxt  = xfer_addr;
                        rem_nxt   = xfer_len;
                        busy_nxt  = 1'b1;
                        state_nxt = READ;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            READ: begin
                load_word = 1'b1;
                valid_nxt = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                if (data_valid && data_ready) begin
                    addr_nxt  = cur_addr + ADDR_W'(1);
                    rem_nxt   = remaining - LEN_W'(1);
                    valid_nxt = 1'b0;
                    if (remaining == LEN_W'(1)) begin
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur_addr   <= '0;
            remaining  <= '0;
            xfer_busy  <= 1'b0;
            data_valid <= 1'b0;
            xfer_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cur_addr   <= addr_nxt;
            remaining  <= rem_nxt;
            xfer_busy  <= busy_nxt;
            data_valid <= valid_nxt;
            xfer_done  <= done_nxt;
        end
    end

    // data_bus doubles as the RAM read register; a same-edge write yields the old word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_bus <= '0;
        end else if (load_word) begin
            data_bus <= fmt_word(mem[cur_addr]);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_bloc_xfer_source.sv
// Bench for bloc_xfer_source: table of bursts checked against a RAM model and a beat scoreboard.
module tb_bloc_xfer_source;

    logic        clk, rst_n;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        xfer_req;
    logic [7:0]  xfer_addr;
    logic [3:0]  xfer_len;
    logic        xfer_busy;
    logic [15:0] data_bus;
    logic        data_valid;
    logic        data_ready;
    logic        xfer_done;

    bloc_xfer_source #(.DATA_W(16), .ADDR_W(8), .LEN_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .xfer_req(xfer_req), .xfer_addr(xfer_addr), .xfer_len(xfer_len),
        .xfer_busy(xfer_busy), .data_bus(data_bus), .data_valid(data_valid),
        .data_ready(data_ready), .xfer_done(xfer_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] model_mem [256];
    logic [15:0] sbq [$];
    logic        held = 1'b0;
    logic [15:0] held_data = '0;
    logic [15:0] mon_exp;

    typedef struct {
        string       nm;
        logic [7:0]  addr;
        logic [3:0]  len;
        int          stall_beat;
        int          stall_cyc;
        int          req_at;
        int          wr_at;
        int          exp_cyc;
        logic [15:0] exp_first;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input logic [15:0] w);
`ifdef BLOC_XFER_BYTE_SWAP_EN
        return {w[7:0], w[15:8]};
`else
        return w;
`endif
    endfunction

    task automatic ram_write(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        model_mem[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Beat monitor: pops the scoreboard on each handshake and checks held data stays stable
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (data_valid && data_ready) begin
                if (sbq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL beat_unexpected: got 0x%0h required no beat", data_bus);
                end else begin
                    mon_exp = sbq.pop_front();
                    check("beat_data", {16'h0, data_bus}, {16'h0, mon_exp});
                end
            end
            if (held && data_valid) check("hold_stable", {16'h0, data_bus}, {16'h0, held_data});
            held = data_valid && !data_ready;
            held_data = data_bus;
            if (xfer_done) check("done_busy_low", {31'h0, xfer_busy}, 32'h0);
        end else begin
            held = 1'b0;
        end
    end

    task automatic run_burst(input vec_t v);
        int   cyc, beat, left;
        logic got, first_seen;
        for (int i = 0; i < int'(v.len); i++) sbq.push_back(exp_word(model_mem[8'(v.addr + i)]));
        @(negedge clk);
        xfer_req = 1'b1; xfer_addr = v.addr; xfer_len = v.len; data_ready = 1'b1;
        cyc = 0; beat = 0; left = v.stall_cyc; got = 1'b0; first_seen = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                xfer_req = 1'b0;
                if (v.len != 0) begin
                    check({v.nm, "_busy_start"}, {31'h0, xfer_busy}, 32'h1);
                    check({v.nm, "_valid_early"}, {31'h0, data_valid}, 32'h0);
                end
            end
            if (cyc == 2 && v.len != 0) check({v.nm, "_valid_first"}, {31'h0, data_valid}, 32'h1);
            if (cyc == v.req_at) begin
                xfer_req = 1'b1; xfer_addr = 8'hFE; xfer_len = 4'd3;
            end else if (cyc == v.req_at + 1) begin
                xfer_req = 1'b0;
            end
            if (cyc == v.wr_at) begin
                wr_en = 1'b1; wr_addr = v.addr; wr_data = 16'h5555;
                model_mem[v.addr] = 16'h5555;
            end else if (cyc == v.wr_at + 1) begin
                wr_en = 1'b0;
            end
            if (xfer_done) begin
                got = 1'b1;
                check({v.nm, "_done_cycle"}, cyc, v.exp_cyc);
            end else begin
                if (data_valid && beat == v.stall_beat && left > 0) begin
                    data_ready = 1'b0;
                    left--;
                end else begin
                    data_ready = 1'b1;
                end
                if (data_valid && data_ready) begin
                    if (!first_seen) check({v.nm, "_first_word"}, {16'h0, data_bus}, {16'h0, exp_word(v.exp_first)});
                    first_seen = 1'b1;
                    beat++;
                end
            end
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: got no xfer_done required one within 200 cycles", v.nm);
        end
        wr_en = 1'b0;
        data_ready = 1'b1;
        @(negedge clk);
        #1;
        check({v.nm, "_done_pulse"}, {31'h0, xfer_done}, 32'h0);
        check({v.nm, "_busy_end"}, {31'h0, xfer_busy}, 32'h0);
        check({v.nm, "_beats_left"}, sbq.size(), 32'h0);
        sbq.delete();
    endtask

    initial begin
        int cyc, beat;
        vecs[0] = '{"basic",       8'h10, 4'd5,  -1, 0, -1, -1, 11, 16'hA000};
        vecs[1] = '{"stall",       8'h10, 4'd5,   1, 3, -1, -1, 14, 16'hA000};
        vecs[2] = '{"wrap",        8'hFE, 4'd3,  -1, 0, -1, -1,  7, 16'h1111};
        vecs[3] = '{"zero_len",    8'h10, 4'd0,  -1, 0, -1, -1,  1, 16'h0000};
        vecs[4] = '{"single",      8'h20, 4'd1,  -1, 0, -1, -1,  3, 16'h12AB};
        vecs[5] = '{"ignore_req",  8'h10, 4'd2,  -1, 0,  2, -1,  5, 16'hA000};
        vecs[6] = '{"rw_collide",  8'h30, 4'd1,  -1, 0, -1,  1,  3, 16'h0C0C};
        vecs[7] = '{"after_write", 8'h30, 4'd1,  -1, 0, -1, -1,  3, 16'h5555};
        vecs[8] = '{"max_len",     8'h40, 4'd15,  0, 2, -1, -1, 33, 16'hB000};

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        xfer_req = 1'b0; xfer_addr = '0; xfer_len = '0; data_ready = 1'b1;
        for (int i = 0; i < 256; i++) model_mem[i] = 16'h0;
        #1;
        check("reset_busy",  {31'h0, xfer_busy},  32'h0);
        check("reset_valid", {31'h0, data_valid}, 32'h0);
        check("reset_done",  {31'h0, xfer_done},  32'h0);
        check("reset_data",  {16'h0, data_bus},   32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) ram_write(8'(8'h10 + i), 16'(16'hA000 + i));
        ram_write(8'hFE, 16'h1111);
        ram_write(8'hFF, 16'h2222);
        ram_write(8'h00, 16'h3333);
        ram_write(8'h20, 16'h12AB);
        ram_write(8'h30, 16'h0C0C);
        for (int i = 0; i < 15; i++) ram_write(8'(8'h40 + i), 16'(16'hB000 + i));

        for (int i = 0; i < 9; i++) run_burst(vecs[i]);

        // Reset asserted during a burst, right after the second beat
        for (int i = 0; i < 5; i++) sbq.push_back(exp_word(model_mem[8'(8'h10 + i)]));
        @(negedge clk);
        xfer_req = 1'b1; xfer_addr = 8'h10; xfer_len = 4'd5; data_ready = 1'b1;
        cyc = 0; beat = 0;
        while (beat < 2 && cyc < 50) begin
            @(negedge clk);
            #1;
            cyc++;
            if (cyc == 1) xfer_req = 1'b0;
            if (data_valid && data_ready) beat++;
        end
        check("rst_mid_beats", beat, 32'd2);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy",  {31'h0, xfer_busy},  32'h0);
        check("rst_mid_valid", {31'h0, data_valid}, 32'h0);
        check("rst_mid_done",  {31'h0, xfer_done},  32'h0);
        check("rst_mid_data",  {16'h0, data_bus},   32'h0);
        sbq.delete();
        repeat (2) begin
            @(negedge clk);
            #1;
            check("rst_hold_done", {31'h0, xfer_done}, 32'h0);
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            check("rst_rel_done",  {31'h0, xfer_done},  32'h0);
            check("rst_rel_busy",  {31'h0, xfer_busy},  32'h0);
            check("rst_rel_valid", {31'h0, data_valid}, 32'h0);
        end
        run_burst(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
